// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, fixed-latency memory between the
// fetch stage (instruction reads) and the memory stage (loads/stores).
// One transaction is granted at a time. The next grant may overlap the
// response cycle of the current one. The read response is routed back to
// the requester that owns the transaction.
// Optional feature: define ARB_RR_EN for round-robin arbitration on conflict.
// Without it, the data port always wins a conflict.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2     // legal range 1..15
) (
  input  logic              clk,
  input  logic              rst,
  // fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  // data port
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  // memory macro
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  // pipeline hold
  output logic              stall_f,
  output logic              stall_m
);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);

  state_t            state, stateNext;
  logic [3:0]        latCnt;
  owner_t            owner;
  logic              ownerWe;
  logic [DATA_W-1:0] ifHold, dmHold;
`ifdef ARB_RR_EN
  owner_t            lastWinner;
`endif

  logic grantOk;
  logic respCycle;
  logic dmWins;
  logic ifGrant;
  logic dmGrant;

  // Arbitration: a grant may be issued when idle or in the response cycle.
  always_comb begin
    respCycle = (state == BUSY) && (latCnt == 4'd1);
    grantOk   = (state == IDLE) || respCycle;
`ifdef ARB_RR_EN
    // On conflict the requester that did not win last time takes the port.
    dmWins    = dm_req && (!if_req || (lastWinner == OWN_IF));
`else
    dmWins    = dm_req;
`endif
    dmGrant   = !rst && grantOk && dmWins;
    ifGrant   = !rst && grantOk && if_req && !dmWins;
  end

  // Next state and all outputs. Every output is forced to 0 while rst is high.
  always_comb begin
    // NOTE: every signal written here gets a default first. Otherwise a path
    // that skips an assignment would infer a latch.
    stateNext = state;
    if_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    if_rvalid = 1'b0;
    dm_rvalid = 1'b0;
    if_rdata  = '0;
    dm_rdata  = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    stall_f   = 1'b0;
    stall_m   = 1'b0;

    if (!rst) begin
      if (ifGrant || dmGrant) begin
        stateNext = BUSY;
      end else if (respCycle) begin
        stateNext = IDLE;
      end

      if_gnt  = ifGrant;
      dm_gnt  = dmGrant;
      mem_req = ifGrant || dmGrant;
      if (dmGrant) begin
        mem_we    = dm_we;
        mem_addr  = dm_addr;
        mem_wdata = dm_wdata;
      end else if (ifGrant) begin
        mem_addr  = if_addr;
      end

      if_rvalid = respCycle && (owner == OWN_IF) && !ownerWe;
      dm_rvalid = respCycle && (owner == OWN_DM) && !ownerWe;
      if_rdata  = if_rvalid ? mem_rdata : ifHold;
      dm_rdata  = dm_rvalid ? mem_rdata : dmHold;

      // A stage holds while it waits for a grant, and from the grant
      // through to the cycle its read data returns.
      stall_f = (if_req && !ifGrant) || ifGrant ||
                ((state == BUSY) && (owner == OWN_IF) && !ownerWe);
      stall_m = (dm_req && !dmGrant) || dmGrant ||
                ((state == BUSY) && (owner == OWN_DM) && !ownerWe);
    end
  end

  // State register, latency counter, owner tracking and response hold registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments. This way every
    // register samples the pre-edge values, whatever order the statements are in.
    if (rst) begin
      state      <= IDLE;
      latCnt     <= 4'd0;
      owner      <= OWN_IF;
      ownerWe    <= 1'b0;
      ifHold     <= '0;
      dmHold     <= '0;
`ifdef ARB_RR_EN
      lastWinner <= OWN_IF;
`endif
    end else begin
      state <= stateNext;
      if (ifGrant || dmGrant) begin
        latCnt  <= LAT_INIT;
        owner   <= dmGrant ? OWN_DM : OWN_IF;
        ownerWe <= dmGrant && dm_we;
`ifdef ARB_RR_EN
        lastWinner <= dmGrant ? OWN_DM : OWN_IF;
`endif
      end else if (state == BUSY) begin
        latCnt <= latCnt - 4'd1;
      end
      if (if_rvalid) ifHold <= mem_rdata;
      if (dm_rvalid) dmHold <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. Instance dut uses MEM_LAT=2 and
// covers fetch, conflict, store, continuous conflict and reset in flight.
// Instance dut1 uses MEM_LAT=1 and covers back-to-back fetches.
// Each instance has a simple fixed-latency memory model.
// Read data is addr ^ 0xA5A50000, except address 0x10, which returns 0x00500093.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // MEM_LAT = 2 instance signals
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall_f, stall_m;

  // MEM_LAT = 1 instance signals
  logic        b_if_req, b_if_gnt, b_if_rvalid;
  logic [31:0] b_if_addr, b_if_rdata;
  logic        b_dm_req, b_dm_we, b_dm_gnt, b_dm_rvalid;
  logic [31:0] b_dm_addr, b_dm_wdata, b_dm_rdata;
  logic        b_mem_req, b_mem_we;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_stall_f, b_stall_m;

  int nChecks = 0;
  int nFails  = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_f(stall_f), .stall_m(stall_m)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
    .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
    .dm_gnt(b_dm_gnt), .dm_rvalid(b_dm_rvalid), .dm_rdata(b_dm_rdata),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
    .stall_f(b_stall_f), .stall_m(b_stall_m)
  );

  function automatic logic [31:0] memData(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h0050_0093;
    return a ^ 32'hA5A5_0000;
  endfunction

  // Fixed-latency memory models: a read launched in cycle T appears in T+MEM_LAT.
  logic [31:0] p1, p2, bp1;
  always @(posedge clk) begin
    p1  <= (mem_req && !mem_we) ? memData(mem_addr) : 32'h0;
    p2  <= p1;
    bp1 <= (b_mem_req && !b_mem_we) ? memData(b_mem_addr) : 32'h0;
  end
  assign mem_rdata   = p2;
  assign b_mem_rdata = bp1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Move to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling (well before next edge).
  task automatic settle();
    #2;
  endtask

  initial begin
    if_req = 1'b1; if_addr = 32'h10;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'h1234_5678;
    b_if_req = 1'b1; b_if_addr = 32'h4;
    b_dm_req = 1'b0; b_dm_we = 1'b0; b_dm_addr = 32'h0; b_dm_wdata = 32'h0;

    // ---- Reset: all outputs 0 while rst is high, even with requests present
    settle();
    check("rst if_gnt",   {31'b0, if_gnt},   32'h0);
    check("rst dm_gnt",   {31'b0, dm_gnt},   32'h0);
    check("rst mem_req",  {31'b0, mem_req},  32'h0);
    check("rst mem_we",   {31'b0, mem_we},   32'h0);
    check("rst mem_addr", mem_addr,          32'h0);
    check("rst stall_f",  {31'b0, stall_f},  32'h0);
    check("rst stall_m",  {31'b0, stall_m},  32'h0);
    check("rst b_if_gnt", {31'b0, b_if_gnt}, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    if_req = 1'b0; if_addr = 32'h0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0;
    b_if_req = 1'b0; b_if_addr = 32'h0;
    settle();
    check("idle mem_req",  {31'b0, mem_req}, 32'h0);
    check("idle stall_f",  {31'b0, stall_f}, 32'h0);
    check("idle if_rdata", if_rdata,         32'h0);

    // ---- Lone fetch at 0x10
    tick();
    if_req = 1'b1; if_addr = 32'h10;
    settle();
    check("f1 T if_gnt",   {31'b0, if_gnt},  32'h1);
    check("f1 T mem_req",  {31'b0, mem_req}, 32'h1);
    check("f1 T mem_addr", mem_addr,         32'h10);
    check("f1 T mem_we",   {31'b0, mem_we},  32'h0);
    check("f1 T stall_f",  {31'b0, stall_f}, 32'h1);
    tick();
    if_req = 1'b0; if_addr = 32'h0;
    settle();
    check("f1 T+1 stall_f",   {31'b0, stall_f},   32'h1);
    check("f1 T+1 if_rvalid", {31'b0, if_rvalid}, 32'h0);
    check("f1 T+1 mem_req",   {31'b0, mem_req},   32'h0);
    tick();
    settle();
    check("f1 T+2 if_rvalid", {31'b0, if_rvalid}, 32'h1);
    check("f1 T+2 if_rdata",  if_rdata,           32'h0050_0093);
    check("f1 T+2 stall_f",   {31'b0, stall_f},   32'h1);
    tick();
    settle();
    check("f1 T+3 if_rvalid", {31'b0, if_rvalid}, 32'h0);
    check("f1 T+3 if_rdata",  if_rdata,           32'h0050_0093);
    check("f1 T+3 stall_f",   {31'b0, stall_f},   32'h0);

    // ---- Conflict in IDLE: fetch 0x20 vs load 0x100, DM wins
    tick();
    if_req = 1'b1; if_addr = 32'h20;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
    settle();
    check("c T dm_gnt",   {31'b0, dm_gnt},  32'h1);
    check("c T if_gnt",   {31'b0, if_gnt},  32'h0);
    check("c T mem_addr", mem_addr,         32'h100);
    check("c T stall_f",  {31'b0, stall_f}, 32'h1);
    check("c T stall_m",  {31'b0, stall_m}, 32'h1);
    tick();
    dm_req = 1'b0; dm_addr = 32'h0;
    settle();
    check("c T+1 if_gnt",  {31'b0, if_gnt},  32'h0);
    check("c T+1 stall_f", {31'b0, stall_f}, 32'h1);
    tick();
    settle();
    check("c T+2 dm_rvalid", {31'b0, dm_rvalid}, 32'h1);
    check("c T+2 dm_rdata",  dm_rdata,           32'hA5A5_0100);
    check("c T+2 if_gnt",    {31'b0, if_gnt},    32'h1);
    check("c T+2 mem_addr",  mem_addr,           32'h20);
    check("c T+2 stall_m",   {31'b0, stall_m},   32'h1);
    tick();
    if_req = 1'b0; if_addr = 32'h0;
    settle();
    check("c T+3 dm_rvalid", {31'b0, dm_rvalid}, 32'h0);
    check("c T+3 dm_rdata",  dm_rdata,           32'hA5A5_0100);
    check("c T+3 stall_m",   {31'b0, stall_m},   32'h0);
    tick();
    settle();
    check("c T+4 if_rvalid", {31'b0, if_rvalid}, 32'h1);
    check("c T+4 if_rdata",  if_rdata,           32'hA5A5_0020);

    // ---- Store 0xDEADBEEF to 0x200, then a fetch waits for the port
    tick();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF;
    settle();
    check("s T dm_gnt",    {31'b0, dm_gnt},  32'h1);
    check("s T mem_we",    {31'b0, mem_we},  32'h1);
    check("s T mem_addr",  mem_addr,         32'h200);
    check("s T mem_wdata", mem_wdata,        32'hDEAD_BEEF);
    check("s T stall_m",   {31'b0, stall_m}, 32'h1);
    tick();
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0;
    if_req = 1'b1; if_addr = 32'h30;
    settle();
    check("s T+1 stall_m", {31'b0, stall_m}, 32'h0);
    check("s T+1 if_gnt",  {31'b0, if_gnt},  32'h0);
    check("s T+1 mem_we",  {31'b0, mem_we},  32'h0);
    tick();
    settle();
    check("s T+2 dm_rvalid", {31'b0, dm_rvalid}, 32'h0);
    check("s T+2 if_gnt",    {31'b0, if_gnt},    32'h1);
    check("s T+2 mem_addr",  mem_addr,           32'h30);
    tick();
    if_req = 1'b0; if_addr = 32'h0;
    settle();
    check("s T+3 dm_rvalid", {31'b0, dm_rvalid}, 32'h0);
    tick();
    settle();
    check("s T+4 if_rvalid", {31'b0, if_rvalid}, 32'h1);
    check("s T+4 if_rdata",  if_rdata,           32'hA5A5_0030);

    // ---- Continuous conflict: fetch 0x40 vs load 0x140 for 8 cycles
    tick();
    if_req = 1'b1; if_addr = 32'h40;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h140;
    for (int k = 0; k < 8; k++) begin
      logic expIf, expDm;
      settle();
`ifdef ARB_RR_EN
      expDm = (k % 4) == 0;
      expIf = (k % 4) == 2;
`else
      expDm = (k % 2) == 0;
      expIf = 1'b0;
`endif
      check($sformatf("rr k%0d dm_gnt", k), {31'b0, dm_gnt}, {31'b0, expDm});
      check($sformatf("rr k%0d if_gnt", k), {31'b0, if_gnt}, {31'b0, expIf});
      tick();
    end
    if_req = 1'b0; if_addr = 32'h0;
    dm_req = 1'b0; dm_addr = 32'h0;
    settle();
`ifdef ARB_RR_EN
    check("rr tail if_rvalid", {31'b0, if_rvalid}, 32'h1);
    check("rr tail if_rdata",  if_rdata,           32'hA5A5_0040);
`else
    check("rr tail dm_rvalid", {31'b0, dm_rvalid}, 32'h1);
    check("rr tail dm_rdata",  dm_rdata,           32'hA5A5_0140);
`endif

    // ---- Reset pulsed one cycle after a load grant
    tick();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h180;
    settle();
    check("r T dm_gnt", {31'b0, dm_gnt}, 32'h1);
    tick();
    dm_req = 1'b0; dm_addr = 32'h0;
    rst = 1'b1;
    settle();
    check("r T+1 stall_m",   {31'b0, stall_m},   32'h0);
    check("r T+1 mem_req",   {31'b0, mem_req},   32'h0);
    check("r T+1 dm_rvalid", {31'b0, dm_rvalid}, 32'h0);
    tick();
    rst = 1'b0;
    settle();
    check("r T+2 dm_rvalid", {31'b0, dm_rvalid}, 32'h0);
    check("r T+2 stall_m",   {31'b0, stall_m},   32'h0);
    tick();
    settle();
    check("r T+3 dm_rvalid", {31'b0, dm_rvalid}, 32'h0);
    check("r T+3 dm_rdata",  dm_rdata,           32'h0);
    tick();
    if_req = 1'b1; if_addr = 32'h44;
    settle();
    check("r new if_gnt", {31'b0, if_gnt}, 32'h1);
    tick();
    if_req = 1'b0; if_addr = 32'h0;
    tick();
    settle();
    check("r new if_rvalid", {31'b0, if_rvalid}, 32'h1);
    check("r new if_rdata",  if_rdata,           32'hA5A5_0044);

    // ---- MEM_LAT = 1: back-to-back fetches 0x0, 0x4, 0x8
    tick();
    b_if_req = 1'b1; b_if_addr = 32'h0;
    settle();
    check("b0 if_gnt",    {31'b0, b_if_gnt},    32'h1);
    check("b0 if_rvalid", {31'b0, b_if_rvalid}, 32'h0);
    tick();
    b_if_addr = 32'h4;
    settle();
    check("b1 if_gnt",    {31'b0, b_if_gnt},    32'h1);
    check("b1 mem_addr",  b_mem_addr,           32'h4);
    check("b1 if_rvalid", {31'b0, b_if_rvalid}, 32'h1);
    check("b1 if_rdata",  b_if_rdata,           32'hA5A5_0000);
    tick();
    b_if_addr = 32'h8;
    settle();
    check("b2 if_gnt",    {31'b0, b_if_gnt},    32'h1);
    check("b2 if_rvalid", {31'b0, b_if_rvalid}, 32'h1);
    check("b2 if_rdata",  b_if_rdata,           32'hA5A5_0004);
    tick();
    b_if_req = 1'b0; b_if_addr = 32'h0;
    settle();
    check("b3 if_gnt",    {31'b0, b_if_gnt},    32'h0);
    check("b3 if_rvalid", {31'b0, b_if_rvalid}, 32'h1);
    check("b3 if_rdata",  b_if_rdata,           32'hA5A5_0008);
    tick();
    settle();
    check("b4 if_rvalid", {31'b0, b_if_rvalid}, 32'h0);
    check("b4 if_rdata",  b_if_rdata,           32'hA5A5_0008);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported unified memory between the Fetch stage (instruction reads) and the Memory stage (data loads/stores) of the 5-stage RISC-V pipeline. It grants one requester per transaction, sequences the fixed-latency memory access, routes the read response back, and raises stall signals so the pipeline holds while a requester waits. It sits between the Fetch_Cycle/Memory_Cycle stages and the memory macro.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, cycles from memory request to read data valid; legal range 1..15

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch read request
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid (1-cycle pulse)
- if_rdata  out  DATA_W  fetch read data
- dm_req  in  1  data request
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_gnt  out  1  data request accepted this cycle
- dm_rvalid  out  1  load data valid (1-cycle pulse; never for stores)
- dm_rdata  out  DATA_W  load data
- mem_req  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_req
- stall_f  out  1  if_req & ~if_gnt, or fetch read outstanding
- stall_m  out  1  dm_req & ~dm_gnt, or data load outstanding

## Operation
- States: IDLE, BUSY. Registers: state, lat_cnt (4 bits), owner (IF/DM), owner_we, last_winner, if_hold, dm_hold.
- Grant is allowed when state = IDLE, or state = BUSY and lat_cnt = 1 (response cycle). Grant is combinational from requests.
- Winner when only one requests: that one. When both request: DM wins (fixed priority); see Configuration.
- On grant: mem_req = 1; mem_addr/mem_we/mem_wdata driven from the winner the same cycle (IF: mem_we = 0, mem_wdata = 0). Next state BUSY, lat_cnt = MEM_LAT, owner = winner, owner_we = winner write.
- In BUSY, lat_cnt decrements each cycle. At lat_cnt = 1: if owner is a read, owner's rvalid = 1 and owner's rdata = mem_rdata, also captured into owner hold register. Without a new grant, next state IDLE.
- Outside rvalid, *_rdata output the hold register (last returned value).
- Requester holds req and address/data stable until its gnt; a request dropped before gnt is ignored, no error.
- Stores: occupy the port MEM_LAT cycles; no rvalid. stall_m deasserts the cycle after dm_gnt for stores.
- When idle with no request, mem_req = 0 and mem_addr/mem_wdata = 0.

## Timing
- Reset (async): state IDLE, lat_cnt 0, owner IF, last_winner IF, holds 0; all outputs 0 while rst is high.
- Read latency: gnt in cycle T -> rvalid in cycle T+MEM_LAT.
- Throughput: one transaction per MEM_LAT cycles; MEM_LAT = 1 gives one per cycle with rvalid and the next gnt in the same cycle.
- Simultaneous response and new grant in one cycle: response routed to old owner, owner/lat_cnt reloaded for new winner.
- Reset mid-transaction: outstanding response dropped, no rvalid after reset release.

## Configuration
- ARB_RR_EN defined: round-robin on conflict. The requester not equal to last_winner wins. last_winner updates on every grant. Reset value IF, so DM wins the first conflict.
- ARB_RR_EN undefined: DM always wins on conflict. last_winner is not implemented. IF may starve under continuous DM requests.

## Test plan
- MEM_LAT=2, lone fetch at addr 0x10, memory returns 0x00500093 -> if_gnt at T, mem_req/addr 0x10 at T, if_rvalid with 0x00500093 at T+2, stall_f high T..T+2.
- Conflict in IDLE: if_req and dm load at 0x100 -> dm_gnt at T, if_gnt at T+2, dm_rvalid T+2, if_rvalid T+4.
- ARB_RR_EN with both requesting continuously: grants alternate DM, IF, DM, IF every 2 cycles. Without macro: DM granted every time and if_gnt never asserted.
- Store dm_we=1 addr 0x200 wdata 0xDEADBEEF -> mem_we=1, mem_wdata 0xDEADBEEF at T, no dm_rvalid, next grant allowed at T+2.
- MEM_LAT=1, back-to-back fetches 0x0, 0x4, 0x8 -> if_gnt every cycle, if_rvalid every cycle one cycle after each grant.
- rst pulsed at T+1 after a load grant at T -> all outputs 0, no dm_rvalid after release, next request granted normally.
